core_program_loader: RTL
========================

CORE_PROGRAM_LOADER -- requirements
Module: core_program_loader

Interface
REQ-001 Parameter ADDR_W, default 8, SHALL set the instruction word-address width; capacity is 2^ADDR_W words.
REQ-002 Parameter RUN_W, default 16, SHALL set the run-cycle counter width.
REQ-003 clk  input  1  single clock; all logic SHALL be rising-edge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  begin a load-and-run sequence; honoured only in IDLE.
REQ-006 abort  input  1  return to IDLE from any non-IDLE state.
REQ-007 run_cycles  input  RUN_W  number of cycles the core runs; sampled when start is accepted.
REQ-008 s_valid  input  1  instruction word valid.
REQ-009 s_data  input  32  instruction word.
REQ-010 s_last  input  1  marks the final instruction word.
REQ-011 s_ready  output  1  loader accepts a word.
REQ-012 instruction_write  output  1  one-cycle write strobe to the core instruction memory.
REQ-013 instruction_data  output  32  word being written.
REQ-014 instruction_addr  output  ADDR_W  word address being written.
REQ-015 mem_reset_n  output  1  active-low data-memory clear to the core.
REQ-016 core_reset_n  output  1  active-low core/PC reset.
REQ-017 o_running  output  1  core is executing.
REQ-018 o_done  output  1  one-cycle completion pulse.
REQ-019 word_count  output  ADDR_W+1  words loaded in the current or most recent sequence.

Function
REQ-020 The FSM SHALL use states IDLE, LOAD, FLUSH, RUN, DONE.
REQ-021 All outputs SHALL be registered, except s_ready, which SHALL be 1 exactly when state==LOAD.
REQ-022 IDLE: start=1 SHALL move the FSM to LOAD, clear the address pointer and word_count, and latch run_cycles.
REQ-023 mem_reset_n SHALL be 0 for exactly the first LOAD cycle after start is accepted, and 1 otherwise.
REQ-024 core_reset_n SHALL be 0 in IDLE, LOAD and FLUSH, and 1 in RUN and DONE.
REQ-025 LOAD: each handshake (s_valid & s_ready) at cycle t SHALL produce instruction_write=1 at t+1 for one cycle, with instruction_data=s_data and instruction_addr=pointer; the pointer and word_count SHALL then increment.
REQ-026 Back-to-back handshakes SHALL be accepted every cycle with no bubbles.
REQ-027 A handshake with s_last=1, or on pointer 2^ADDR_W-1 (forced last), SHALL move the FSM to FLUSH; the pointer SHALL never wrap.
REQ-028 FLUSH SHALL last one cycle, during which the final write is presented; it SHALL then move to RUN if latched run_cycles!=0, else to DONE.
REQ-029 RUN: o_running SHALL be 1 for exactly the latched run_cycles cycles, counted down from the latched value; the count reaching 1 SHALL move the FSM to DONE.
REQ-030 DONE: o_done SHALL be 1 for one cycle, then the FSM SHALL return to IDLE.
REQ-031 abort in LOAD, FLUSH or RUN SHALL force IDLE on the next cycle; o_done SHALL not pulse; any write already registered SHALL still complete its single cycle.
REQ-032 abort in DONE SHALL have no effect; abort and start together in IDLE SHALL mean start wins.
REQ-033 start outside IDLE SHALL be ignored, including changes on run_cycles.
REQ-034 instruction_write SHALL be 0 in every state other than the cycle after a handshake.

Reset
REQ-035 reset=1 at a clock edge SHALL force IDLE and set instruction_write=0, instruction_data=0, instruction_addr=0, mem_reset_n=1, core_reset_n=0, o_running=0, o_done=0, word_count=0, and the latched run count to 0.
REQ-036 reset SHALL override start, abort and in-progress handshakes; a reset mid-LOAD or mid-RUN SHALL produce no further writes and no o_done.

Verification
REQ-037 Verify: start, run_cycles=5, then 3 words 0x00500093/0x00100113/0x002081B3 back-to-back with s_last on the third -> writes at addr 0,1,2 on consecutive cycles, one FLUSH cycle, o_running for exactly 5 cycles, o_done for 1 cycle, word_count=3.
REQ-038 Verify: s_valid toggled with gaps in LOAD -> one write per handshake only, addresses contiguous, no duplicate writes.
REQ-039 Verify: ADDR_W=8, 256 words with no s_last -> the word at addr 255 is forced last, FLUSH is entered, word_count=256, and no write to addr 0 follows.
REQ-040 Verify: run_cycles=0 -> FLUSH goes directly to DONE, o_running never asserts, and o_done pulses once.
REQ-041 Verify: abort in the 2nd RUN cycle -> IDLE next cycle, o_running=0, core_reset_n=0, and no o_done; a new start then completes normally.
REQ-042 Verify: reset asserted mid-LOAD after 2 words -> all outputs at the REQ-035 values the next cycle, and s_ready=0.

Source files
------------

// File: rtl/core_program_loader.sv
// Program loader: streams instruction words into the core's instruction
// memory, clears data memory, releases the core for a fixed number of
// cycles, then signals completion.
module core_program_loader #(
    parameter int ADDR_W = 8,
    parameter int RUN_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [RUN_W-1:0]  run_cycles,
    input  logic              s_valid,
    input  logic [31:0]       s_data,
    input  logic              s_last,
    output logic              s_ready,
    output logic              instruction_write,
    output logic [31:0]       instruction_data,
    output logic [ADDR_W-1:0] instruction_addr,
    output logic              mem_reset_n,
    output logic              core_reset_n,
    output logic              o_running,
    output logic              o_done,
    output logic [ADDR_W:0]   word_count
);

    typedef enum logic [2:0] {IDLE, LOAD, FLUSH, RUN, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [RUN_W-1:0] run_cnt;
    logic             handshake;
    logic             wr_en;
    logic             ptr_max;

    assign s_ready = (state == LOAD);

    // Handshake qualification; the low bits of word_count double as the write pointer
    always_comb begin
        handshake = s_valid && s_ready;
        wr_en     = handshake && !abort;
        ptr_max   = (word_count[ADDR_W-1:0] == '1);
    end

    // Next-state selection
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (start) state_next = LOAD;
            LOAD: begin
                if (abort)
                    state_next = IDLE;
                else if (handshake && (s_last || ptr_max))
                    state_next = FLUSH;
            end
            FLUSH: begin
                if (abort)
                    state_next = IDLE;
                else if (run_cnt != '0)
                    state_next = RUN;
                else
                    state_next = DONE;
            end
            RUN: begin
                if (abort)
                    state_next = IDLE;
                else if (run_cnt == RUN_W'(1))
                    state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Registered outputs, write port and run counter
    always_ff @(posedge clk) begin
        if (reset) begin
            instruction_write <= 1'b0;
            instruction_data  <= '0;
            instruction_addr  <= '0;
            mem_reset_n       <= 1'b1;
            core_reset_n      <= 1'b0;
            o_running         <= 1'b0;
            o_done            <= 1'b0;
            word_count        <= '0;
            run_cnt           <= '0;
        end else begin
            instruction_write <= 1'b0;
            mem_reset_n       <= 1'b1;
            if (state == IDLE && start) begin
                word_count  <= '0;
                run_cnt     <= run_cycles;
                mem_reset_n <= 1'b0;
            end
            if (wr_en) begin
                instruction_write <= 1'b1;
                instruction_data  <= s_data;
                instruction_addr  <= word_count[ADDR_W-1:0];
                word_count        <= word_count + 1'b1;
            end
            if (state == RUN)
                run_cnt <= run_cnt - 1'b1;
            // Decoded from the next state so these line up with the state they describe
            core_reset_n <= (state_next == RUN) || (state_next == DONE);
            o_running    <= (state_next == RUN);
            o_done       <= (state_next == DONE);
        end
    end

endmodule
